// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: two-port writeback arbiter for the 8 x 16-bit register file.
// Port 0 (ALU) and port 1 (load/memory) each own a one-entry holding buffer.
// Buffers are granted round-robin onto a registered register-file write port.
// Optional feature: define REG_WB_ARB_FIXED_PRI_EN to give port 1 fixed
// priority whenever both buffers are full.
module reg_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb0_valid,
    input  logic [ADDR_W-1:0]        wb0_dest,
    input  logic [DATA_W-1:0]        wb0_data,
    output logic                     wb0_ready,
    input  logic                     wb1_valid,
    input  logic [ADDR_W-1:0]        wb1_dest,
    input  logic [DATA_W-1:0]        wb1_data,
    output logic                     wb1_ready,
    output logic                     reg_write_en,
    output logic [ADDR_W-1:0]        reg_write_dest,
    output logic [DATA_W-1:0]        reg_write_data,
    output logic [(2**ADDR_W)-1:0]   pending_mask
);

    logic              full0_q, full0_d;
    logic [ADDR_W-1:0] dest0_q, dest0_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic              full1_q, full1_d;
    logic [ADDR_W-1:0] dest1_q, dest1_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_dest_q, wr_dest_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
`ifndef REG_WB_ARB_FIXED_PRI_EN
    logic              last_grant_q, last_grant_d;
`endif
    logic              grant0, grant1;

    // Grant decision from registered buffer state only (no input-to-output path)
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef REG_WB_ARB_FIXED_PRI_EN
        grant1 = full1_q;
        grant0 = full0_q && !full1_q;
`else
        if (full0_q && full1_q) begin
            // last_grant_q == 1 means port 1 went last, so port 0 wins now
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
        end else begin
            grant0 = full0_q;
            grant1 = full1_q;
        end
`endif
    end

    assign wb0_ready = !full0_q || grant0;
    assign wb1_ready = !full1_q || grant1;

    // Buffer refill/drain and output-register next state
    always_comb begin
        full0_d   = full0_q;
        dest0_d   = dest0_q;
        data0_d   = data0_q;
        full1_d   = full1_q;
        dest1_d   = dest1_q;
        data1_d   = data1_q;
        wr_en_d   = 1'b0;
        wr_dest_d = wr_dest_q;
        wr_data_d = wr_data_q;
`ifndef REG_WB_ARB_FIXED_PRI_EN
        last_grant_d = last_grant_q;
`endif

        // A handshake takes priority over the drain, so a granted buffer refills in place
        if (wb0_valid && wb0_ready) begin
            full0_d = 1'b1;
            dest0_d = wb0_dest;
            data0_d = wb0_data;
        end else if (grant0) begin
            full0_d = 1'b0;
        end

        if (wb1_valid && wb1_ready) begin
            full1_d = 1'b1;
            dest1_d = wb1_dest;
            data1_d = wb1_data;
        end else if (grant1) begin
            full1_d = 1'b0;
        end

        if (grant0) begin
            wr_dest_d = dest0_q;
            wr_data_d = data0_q;
            wr_en_d   = (dest0_q != '0);
`ifndef REG_WB_ARB_FIXED_PRI_EN
            last_grant_d = 1'b0;
`endif
        end else if (grant1) begin
            wr_dest_d = dest1_q;
            wr_data_d = data1_q;
            wr_en_d   = (dest1_q != '0);
`ifndef REG_WB_ARB_FIXED_PRI_EN
            last_grant_d = 1'b1;
`endif
        end
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full0_q   <= 1'b0;
            dest0_q   <= '0;
            data0_q   <= '0;
            full1_q   <= 1'b0;
            dest1_q   <= '0;
            data1_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
`ifndef REG_WB_ARB_FIXED_PRI_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            full0_q   <= full0_d;
            dest0_q   <= dest0_d;
            data0_q   <= data0_d;
            full1_q   <= full1_d;
            dest1_q   <= dest1_d;
            data1_q   <= data1_d;
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
`ifndef REG_WB_ARB_FIXED_PRI_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_dest_q;
    assign reg_write_data = wr_data_q;

    // Pending-destination mask; r0 is never reported since its writes are dropped
    always_comb begin
        pending_mask = '0;
        if (full0_q) pending_mask[dest0_q] = 1'b1;
        if (full1_q) pending_mask[dest1_q] = 1'b1;
        if (wr_en_q) pending_mask[wr_dest_q] = 1'b1;
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed vector table, hand-written contention and
// mid-operation reset sequences, and randomized traffic checked against a
// transaction-level model of the two holding buffers and the write port.
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        wb0_valid, wb1_valid;
    logic [2:0]  wb0_dest, wb1_dest;
    logic [15:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [7:0]  pending_mask;

    int checks = 0;
    int errors = 0;

    reg_wb_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_dest(wb0_dest), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_dest(wb1_dest), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .pending_mask(pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_full[2];
    logic [2:0]  m_dst[2];
    logic [15:0] m_dat[2];
    int          m_pref;   // port that wins when both buffers hold a request
    bit          m_en;
    logic [2:0]  m_odst;
    logic [15:0] m_odat;

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_dst[i] = 0; m_dat[i] = 0;
        end
        m_pref = 0; m_en = 0; m_odst = 0; m_odat = 0;
    endfunction

    function automatic int m_winner();
        if (m_full[0] && m_full[1]) begin
`ifdef REG_WB_ARB_FIXED_PRI_EN
            return 1;
`else
            return m_pref;
`endif
        end
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    function automatic bit m_ready(input int p);
        return !m_full[p] || (m_winner() == p);
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 2; i++)
            if (m_full[i] && m_dst[i] != 3'd0) m[m_dst[i]] = 1'b1;
        if (m_en) m[m_odst] = 1'b1;
        return m;
    endfunction

    function automatic void m_clock(input bit acc0, input bit acc1);
        int w;
        w = m_winner();
        if (w >= 0) begin
            m_odst = m_dst[w];
            m_odat = m_dat[w];
            m_en   = (m_dst[w] != 3'd0);
            m_pref = 1 - w;
        end else begin
            m_en = 0;
        end
        if (acc0) begin m_full[0] = 1; m_dst[0] = wb0_dest; m_dat[0] = wb0_data; end
        else if (w == 0) m_full[0] = 0;
        if (acc1) begin m_full[1] = 1; m_dst[1] = wb1_dest; m_dat[1] = wb1_data; end
        else if (w == 1) m_full[1] = 0;
    endfunction

    task automatic idle_inputs();
        wb0_valid = 0; wb0_dest = 0; wb0_data = 0;
        wb1_valid = 0; wb1_dest = 0; wb1_data = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v0; logic [2:0] d0; logic [15:0] x0;
        logic        v1; logic [2:0] d1; logic [15:0] x1;
        logic        r0; logic r1; logic en;
        logic [2:0]  dest; logic [15:0] data; logic [7:0] mask;
    } vec_t;

    vec_t vecs[15];

    bit          racc0, racc1;
    logic [2:0]  exp_first;

    initial begin
        // single write to r3, back-to-back refill of dests 4..7, r0 suppression
        vecs[0]  = '{1, 3'd3, 16'hA5A5, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'h0000, 8'h00};
        vecs[1]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'h0000, 8'h08};
        vecs[2]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd3, 16'hA5A5, 8'h08};
        vecs[3]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd3, 16'hA5A5, 8'h00};
        vecs[4]  = '{1, 3'd4, 16'h4004, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd3, 16'hA5A5, 8'h00};
        vecs[5]  = '{1, 3'd5, 16'h5005, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd3, 16'hA5A5, 8'h10};
        vecs[6]  = '{1, 3'd6, 16'h6006, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd4, 16'h4004, 8'h30};
        vecs[7]  = '{1, 3'd7, 16'h7007, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd5, 16'h5005, 8'h60};
        vecs[8]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd6, 16'h6006, 8'hC0};
        vecs[9]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd7, 16'h7007, 8'h80};
        vecs[10] = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd7, 16'h7007, 8'h00};
        vecs[11] = '{0, 3'd0, 16'h0000, 1, 3'd0, 16'hFFFF, 1, 1, 0, 3'd7, 16'h7007, 8'h00};
        vecs[12] = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd7, 16'h7007, 8'h00};
        vecs[13] = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'hFFFF, 8'h00};
        vecs[14] = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'hFFFF, 8'h00};

        // reset values while rst is held
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst_en",    reg_write_en,   0);
        chk("rst_dest",  reg_write_dest, 0);
        chk("rst_data",  reg_write_data, 0);
        chk("rst_mask",  pending_mask,   0);
        chk("rst_rdy0",  wb0_ready,      1);
        chk("rst_rdy1",  wb1_ready,      1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();

        for (int i = 0; i < 15; i++) begin
            wb0_valid = vecs[i].v0; wb0_dest = vecs[i].d0; wb0_data = vecs[i].x0;
            wb1_valid = vecs[i].v1; wb1_dest = vecs[i].d1; wb1_data = vecs[i].x1;
            #1;
            chk($sformatf("vec%0d_rdy0", i), wb0_ready,      vecs[i].r0);
            chk($sformatf("vec%0d_rdy1", i), wb1_ready,      vecs[i].r1);
            chk($sformatf("vec%0d_en",   i), reg_write_en,   vecs[i].en);
            chk($sformatf("vec%0d_dest", i), reg_write_dest, vecs[i].dest);
            chk($sformatf("vec%0d_data", i), reg_write_data, vecs[i].data);
            chk($sformatf("vec%0d_mask", i), pending_mask,   vecs[i].mask);
            @(posedge clk);
            @(negedge clk);
        end

        // contention: both ports valid continuously, dest 1 vs dest 2
        do_reset();
        wb0_valid = 1; wb0_dest = 3'd1; wb0_data = 16'h1111;
        wb1_valid = 1; wb1_dest = 3'd2; wb1_data = 16'h2222;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c == 0) begin
                chk("cont_rdy0_c0", wb0_ready, 1);
                chk("cont_rdy1_c0", wb1_ready, 1);
                chk("cont_en_c0", reg_write_en, 0);
            end else if (c == 1) begin
`ifdef REG_WB_ARB_FIXED_PRI_EN
                chk("cont_rdy0_c1", wb0_ready, 0);
                chk("cont_rdy1_c1", wb1_ready, 1);
`else
                chk("cont_rdy0_c1", wb0_ready, 1);
                chk("cont_rdy1_c1", wb1_ready, 0);
`endif
                chk("cont_en_c1", reg_write_en, 0);
                chk("cont_mask_c1", pending_mask, 8'h06);
            end else begin
                chk($sformatf("cont_en_c%0d", c), reg_write_en, 1);
                chk($sformatf("cont_mask_c%0d", c), pending_mask, 8'h06);
`ifdef REG_WB_ARB_FIXED_PRI_EN
                chk($sformatf("cont_dest_c%0d", c), reg_write_dest, 3'd2);
                chk($sformatf("cont_rdy0_c%0d", c), wb0_ready, 0);
                chk($sformatf("cont_rdy1_c%0d", c), wb1_ready, 1);
`else
                chk($sformatf("cont_dest_c%0d", c), reg_write_dest, (c % 2 == 0) ? 3'd1 : 3'd2);
                chk($sformatf("cont_data_c%0d", c), reg_write_data, (c % 2 == 0) ? 16'h1111 : 16'h2222);
                chk($sformatf("cont_rdy0_c%0d", c), wb0_ready, (c % 2 == 1) ? 1'b1 : 1'b0);
                chk($sformatf("cont_rdy1_c%0d", c), wb1_ready, (c % 2 == 0) ? 1'b1 : 1'b0);
`endif
            end
            @(posedge clk);
            @(negedge clk);
        end

        // asynchronous reset while both buffers are full and a write is in flight
        chk("midrst_pre_en", reg_write_en, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_en",   reg_write_en, 0);
        chk("midrst_mask", pending_mask, 0);
        chk("midrst_rdy0", wb0_ready, 1);
        chk("midrst_rdy1", wb1_ready, 1);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        #1;
        chk("postrst_en",   reg_write_en, 0);
        chk("postrst_mask", pending_mask, 0);
        wb0_valid = 1; wb0_dest = 3'd5; wb0_data = 16'h5555;
        wb1_valid = 1; wb1_dest = 3'd6; wb1_data = 16'h6666;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
`ifdef REG_WB_ARB_FIXED_PRI_EN
        exp_first = 3'd6;
`else
        exp_first = 3'd5;
`endif
        #1;
        chk("postrst_first_en",   reg_write_en,   1);
        chk("postrst_first_dest", reg_write_dest, exp_first);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            #1;
            chk("rnd_rdy0", wb0_ready,      m_ready(0));
            chk("rnd_rdy1", wb1_ready,      m_ready(1));
            chk("rnd_en",   reg_write_en,   m_en);
            chk("rnd_dest", reg_write_dest, m_odst);
            chk("rnd_data", reg_write_data, m_odat);
            chk("rnd_mask", pending_mask,   m_mask());
            racc0 = wb0_valid && m_ready(0);
            racc1 = wb1_valid && m_ready(1);
            @(posedge clk);
            m_clock(racc0, racc1);
            @(negedge clk);
            // a waiting request stays stable, occasionally withdrawn
            if (wb0_valid && !racc0) begin
                if ($urandom_range(9) == 0) wb0_valid = 0;
            end else begin
                wb0_valid = ($urandom_range(3) != 0);
                wb0_dest  = 3'($urandom_range(7));
                wb0_data  = 16'($urandom);
            end
            if (wb1_valid && !racc1) begin
                if ($urandom_range(9) == 0) wb1_valid = 0;
            end else begin
                wb1_valid = ($urandom_range(3) != 0);
                wb1_dest  = 3'($urandom_range(7));
                wb1_data  = 16'($urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port arbiter and sequencer for the 8 x 16-bit register file. It accepts writeback requests from two independent requesters, the ALU (port 0) and the load/memory unit (port 1). Each port has a valid/ready handshake and a one-entry holding buffer. Ownership of the single register-file write port goes round-robin between the two ports. The arbiter drives registered `reg_write_en`/`reg_write_dest`/`reg_write_data` straight into the register file. A pending-destination mask is exported so issue logic can stall read-after-write hazards.

## Interface
Parameters:
- `DATA_W`, default 16: writeback data width.
- `ADDR_W`, default 3: register address width (2**ADDR_W registers).

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wb0_valid` in 1: ALU request valid.
- `wb0_dest` in ADDR_W: ALU destination register.
- `wb0_data` in DATA_W: ALU write data.
- `wb0_ready` out 1: ALU request accepted this cycle when high together with `wb0_valid`.
- `wb1_valid`, `wb1_dest`, `wb1_data`, `wb1_ready`: same as above, for the load/memory requester.
- `reg_write_en` out 1: register-file write enable (registered).
- `reg_write_dest` out ADDR_W: register-file write address (registered).
- `reg_write_data` out DATA_W: register-file write data (registered).
- `pending_mask` out 2**ADDR_W: bit r is high while a write to register r is held in a buffer or on the output register.

## Operation
- Holding buffers: each port has a one-entry buffer with state `full_i`, `dest_i`, `data_i`.
  - A handshake (`wbi_valid && wbi_ready`) loads the buffer and sets `full_i`.
- Grant: computed only from registered state (`full_0`, `full_1`, `last_grant`).
  - Only one buffer full: grant that buffer.
  - Both full: grant port `!last_grant`.
  - `last_grant` updates to the granted port on every grant.
- Ready: `wbi_ready = !full_i || grant_i`.
  - No combinational path from any input to any output.
  - A granted buffer may be refilled in the same cycle it drains.
- Output register: on a grant, the registered outputs load `reg_write_dest = dest_g` and `reg_write_data = data_g` next edge.
  - `reg_write_en = 1` unless `dest_g == 0`.
  - The granted buffer clears unless it is refilled in the same cycle.
  - With no grant, `reg_write_en = 0`; dest and data hold their previous values.
- Writes to r0: accepted and arbitrated normally, but the write is suppressed (`reg_write_en = 0`). r0 never appears in `pending_mask`.
- `pending_mask`: OR of the one-hot decode of `dest_0` (if `full_0`), `dest_1` (if `full_1`) and `reg_write_dest` (if `reg_write_en`).
- Same destination held in both buffers: both writes are performed in grant order. Write-after-write ordering between ports is the issue logic's responsibility, using `pending_mask`.
- A requester must hold valid/dest/data stable until accepted. Dropping `valid` before acceptance is allowed; the request is simply not taken.

## Timing
- Reset values (asynchronous, immediate on `rst` high):
  - `full_0 = full_1 = 0`, `last_grant = 1` (port 0 wins the first contention).
  - `reg_write_en = 0`, `reg_write_dest = 0`, `reg_write_data = 0`.
  - `pending_mask = 0`.
  - Both `ready` outputs = 1.
- Reset mid-operation discards all buffered and in-flight writes.
- Latency:
  - Request accepted at edge E.
  - Granted in cycle E+1.
  - `reg_write_en` high in cycle E+2.
  - Register file written at edge E+3.
  - `pending_mask` bit is set from E+1 through cycle E+2.
- Throughput:
  - One register-file write per cycle in aggregate.
  - A single uncontended port sustains one write per cycle.
  - Two saturating ports each get one write every 2 cycles, alternating.
- Both buffers full and both requesters valid: only the granted port is ready. The other port's request waits at most one cycle before it is granted.

## Configuration
- `REG_WB_ARB_FIXED_PRI_EN` defined: fixed priority. When both buffers are full, port 1 (load/memory) is always granted and `last_grant` is ignored. Port 0 can starve under continuous port-1 traffic.
- `REG_WB_ARB_FIXED_PRI_EN` undefined (default): round-robin as described under Operation.

## Test plan
- Reset then a single write:
  - Stimulus: release `rst`; pulse `wb0` with dest=3, data=16'hA5A5 for one cycle.
  - Response: `wb0_ready` = 1; `reg_write_en` = 1 with dest 3 / 16'hA5A5 exactly 2 cycles after acceptance; `pending_mask` = 8'b0000_1000 for 2 cycles, then 0.
- Contention, round-robin:
  - Stimulus: both ports valid continuously (`wb0` dest=1, `wb1` dest=2).
  - Response: output writes alternate 1, 2, 1, 2…, with port 0 first after reset; each `ready` toggles high every other cycle.
  - With `REG_WB_ARB_FIXED_PRI_EN` defined: only dest 2 is written while `wb1` stays valid.
- r0 suppression:
  - Stimulus: `wb1` dest=0, data=16'hFFFF.
  - Response: handshake completes; `reg_write_en` stays 0; `pending_mask` stays 0.
- Back-to-back refill:
  - Stimulus: `wb0` valid on 4 consecutive cycles with dests 4, 5, 6, 7.
  - Response: `wb0_ready` stays 1 throughout; four consecutive `reg_write_en` cycles with dests 4, 5, 6, 7.
- Reset mid-operation:
  - Stimulus: assert `rst` asynchronously while both buffers are full and `reg_write_en` = 1.
  - Response: `reg_write_en`, `pending_mask`, `full_0`/`full_1` go to 0 immediately; after release, the first contention is granted to port 0.
